// File: rtl/rename_pkg.sv
// rename_pkg: default sizes, derived index widths and the rename map entry type.
package rename_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int NCKPT_DEF  = 4;
    localparam int REG_IDX_W  = $clog2(NREG_DEF);
    localparam int CKPT_IDX_W = $clog2(NCKPT_DEF);
    typedef struct packed {
        logic                 busy;
        logic [TAG_W_DEF-1:0] tag;
    } map_entry_t;
endpackage

// File: rtl/rename_ckpt_store.sv
// rename_ckpt_store: ring of rename-map snapshots with tag-matched commit clears.
module rename_ckpt_store
    import rename_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NCKPT = NCKPT_DEF,
    localparam int RW = $clog2(NREG),
    localparam int CW = $clog2(NCKPT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic                        flush_i,
    input  logic                        restore_i,
    input  logic [CW-1:0]               restore_id_i,
    input  logic                        take_i,
    input  logic                        release_i,
    input  logic [NREG-1:0]             take_busy_i,
    input  logic [NREG-1:0][TAG_W-1:0]  take_tag_i,
    input  logic                        clr_valid_i,
    input  logic [RW-1:0]               clr_rd_i,
    input  logic [TAG_W-1:0]            clr_tag_i,
    output logic [NREG-1:0]             restore_busy_o,
    output logic [NREG-1:0][TAG_W-1:0]  restore_tag_o,
    output logic [CW-1:0]               id_o,
    output logic                        full_o
);
    logic [NCKPT-1:0][NREG-1:0]            snap_busy_q;
    logic [NCKPT-1:0][NREG-1:0][TAG_W-1:0] snap_tag_q;
    logic [CW-1:0] head_q, tail_q;
    logic [CW:0]   count_q;
    logic          take_ok, rel_ok;

    assign full_o         = count_q == (CW+1)'(NCKPT);
    assign id_o           = tail_q;
    assign take_ok        = take_i && !full_o && !restore_i && !flush_i;
    assign rel_ok         = release_i && count_q != '0;
    assign restore_busy_o = snap_busy_q[restore_id_i];
    assign restore_tag_o  = snap_tag_q[restore_id_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else if (restore_i) begin
                tail_q  <= restore_id_i;
                count_q <= {1'b0, restore_id_i - head_q};
            end else begin
                head_q  <= head_q + CW'(rel_ok);
                tail_q  <= tail_q + CW'(take_ok);
                count_q <= count_q + (CW+1)'(take_ok) - (CW+1)'(rel_ok);
            end
        end
    end

    // Clears hit every slot; dead slots are overwritten on their next take anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_busy_q <= '0;
            snap_tag_q  <= '0;
        end else if (en_i) begin
            for (int s = 0; s < NCKPT; s++) begin
                if (take_ok && tail_q == CW'(s)) begin
                    snap_busy_q[s] <= take_busy_i;
                    snap_tag_q[s]  <= take_tag_i;
                end else if (clr_valid_i && snap_tag_q[s][clr_rd_i] == clr_tag_i) begin
                    snap_busy_q[s][clr_rd_i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file: committed register values plus busy/tag rename map with branch checkpoints.
module reg_rename_file
    import rename_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NCKPT = NCKPT_DEF,
    localparam int RW = $clog2(NREG),
    localparam int CW = $clog2(NCKPT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_all,
    input  logic              issue_valid,
    input  logic [RW-1:0]     issue_rs1,
    input  logic [RW-1:0]     issue_rs2,
    input  logic [RW-1:0]     issue_rd,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [XLEN-1:0]   rs1_value,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [XLEN-1:0]   rs2_value,
    input  logic              commit_valid,
    input  logic [RW-1:0]     commit_rd,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [XLEN-1:0]   commit_value,
    input  logic              ckpt_take,
    output logic [CW-1:0]     ckpt_id,
    output logic              ckpt_full,
    input  logic              ckpt_restore,
    input  logic [CW-1:0]     ckpt_restore_id,
    input  logic              ckpt_release
);
    logic [NREG-1:0][XLEN-1:0]  values_q, values_d;
    logic [NREG-1:0]            busy_q, busy_d, cm_busy, rb_busy;
    logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d, rb_tag;
    logic commit_hit, rs1_nz, rs2_nz, rs1_cm, rs2_cm;

    assign commit_hit = commit_valid && commit_rd != '0;

    // Live map after this cycle's commit clear; this is what a checkpoint captures.
    always_comb begin
        cm_busy = busy_q;
        if (commit_hit && tag_q[commit_rd] == commit_tag) cm_busy[commit_rd] = 1'b0;
    end

    always_comb begin
        values_d = values_q;
        busy_d   = cm_busy;
        tag_d    = tag_q;
        if (commit_hit) values_d[commit_rd] = commit_value;
        if (flush_all) begin
            busy_d = '0;
        end else if (ckpt_restore) begin
            busy_d = rb_busy;
            tag_d  = rb_tag;
            if (commit_hit && rb_tag[commit_rd] == commit_tag) busy_d[commit_rd] = 1'b0;
        end else if (issue_valid && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            values_q <= '0;
            busy_q   <= '0;
            tag_q    <= '0;
        end else if (rdy) begin
            values_q <= values_d;
            busy_q   <= busy_d;
            tag_q    <= tag_d;
        end
    end

    // Reads see committed state plus the retiring result in the same cycle.
    assign rs1_nz    = issue_rs1 != '0;
    assign rs2_nz    = issue_rs2 != '0;
    assign rs1_cm    = commit_valid && commit_rd == issue_rs1;
    assign rs2_cm    = commit_valid && commit_rd == issue_rs2;
    assign rs1_busy  = rs1_nz && busy_q[issue_rs1] && !(rs1_cm && tag_q[issue_rs1] == commit_tag);
    assign rs2_busy  = rs2_nz && busy_q[issue_rs2] && !(rs2_cm && tag_q[issue_rs2] == commit_tag);
    assign rs1_tag   = rs1_nz ? tag_q[issue_rs1] : '0;
    assign rs2_tag   = rs2_nz ? tag_q[issue_rs2] : '0;
    assign rs1_value = !rs1_nz ? '0 : rs1_cm ? commit_value : values_q[issue_rs1];
    assign rs2_value = !rs2_nz ? '0 : rs2_cm ? commit_value : values_q[issue_rs2];

    rename_ckpt_store #(
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .NCKPT (NCKPT)
    ) u_ckpt (
        .clk            (clk),
        .rst            (rst),
        .en_i           (rdy),
        .flush_i        (flush_all),
        .restore_i      (ckpt_restore),
        .restore_id_i   (ckpt_restore_id),
        .take_i         (ckpt_take),
        .release_i      (ckpt_release),
        .take_busy_i    (cm_busy),
        .take_tag_i     (tag_q),
        .clr_valid_i    (commit_hit),
        .clr_rd_i       (commit_rd),
        .clr_tag_i      (commit_tag),
        .restore_busy_o (rb_busy),
        .restore_tag_o  (rb_tag),
        .id_o           (ckpt_id),
        .full_o         (ckpt_full)
    );
endmodule
